// File: rtl/des.sv
// Fully pipelined single-DES encryptor: one Feistel round per stage, every block
// travels with its own key schedule, so a new key/plaintext pair is accepted each cycle.
module des (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_cleartext,
  input  logic [63:0] i_key,
  input  logic        i_dv,
  output logic [63:0] o_ciphertext,
  output logic        o_dv
);

  // Tables hold FIPS 46-3 bit numbers (1 = MSB of the source word).
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is stored row-major: entry = row*16 + column.
  localparam int SBOX [0:7][0:63] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return o;
  endfunction

  // Parity bits (FIPS 8,16,...,64) never appear in PC-1, so they drop out here.
  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return o;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  // Row comes from the outer bits {b1,b6}, column from b2..b5.
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s_out;
    logic [5:0]  six;
    x     = perm_e(r) ^ k;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[6'(47 - 6 * s) -: 6];
      s_out[5'(31 - 4 * s) -: 4] = 4'(SBOX[3'(s)][{six[5], six[0], six[4:1]}]);
    end
    return perm_p(s_out);
  endfunction

  logic [31:0] l_p [0:15];
  logic [31:0] r_p [0:15];
  logic [27:0] c_p [0:15];
  logic [27:0] d_p [0:15];
  logic [15:0] vld_p;

  logic [31:0] l_nx [1:16];
  logic [31:0] r_nx [1:16];
  logic [27:0] c_nx [1:16];
  logic [27:0] d_nx [1:16];

  // Round k logic sits between stage k-1 and stage k; round 16 feeds the output register.
  always_comb begin
    for (int k = 1; k <= 16; k++) begin
      c_nx[5'(k)] = rol28(c_p[4'(k - 1)], SHIFTS[4'(k - 1)]);
      d_nx[5'(k)] = rol28(d_p[4'(k - 1)], SHIFTS[4'(k - 1)]);
      l_nx[5'(k)] = r_p[4'(k - 1)];
      r_nx[5'(k)] = l_p[4'(k - 1)] ^
                    feistel(r_p[4'(k - 1)], perm_pc2({c_nx[5'(k)], d_nx[5'(k)]}));
    end
  end

  // Stage 0 holds IP/PC-1 of the input; stages 1..15 hold the state after that round.
  always_ff @(posedge i_clk) begin
    {l_p[0], r_p[0]} <= perm_ip(i_cleartext);
    {c_p[0], d_p[0]} <= perm_pc1(i_key);
    for (int k = 1; k < 16; k++) begin
      l_p[4'(k)] <= l_nx[5'(k)];
      r_p[4'(k)] <= r_nx[5'(k)];
      c_p[4'(k)] <= c_nx[5'(k)];
      d_p[4'(k)] <= d_nx[5'(k)];
    end
  end

  // Output stage: round 16, final swap and IP^-1; ciphertext holds between valid blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p        <= '0;
      o_dv         <= 1'b0;
      o_ciphertext <= '0;
    end else begin
      vld_p <= {vld_p[14:0], i_dv};
      o_dv  <= vld_p[15];
      if (vld_p[15]) o_ciphertext <= perm_fp({r_nx[16], l_nx[16]});
    end
  end

endmodule

// File: tb/tb_des.sv
// Bench for des: directed known-answer vectors, gaps, parity, reset and a random stream
// checked against a bit-array DES reference through a timed scoreboard.
module tb_des;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_dv;
  logic [63:0] i_cleartext;
  logic [63:0] i_key;
  logic [63:0] o_ciphertext;
  logic        o_dv;

  des dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cleartext(i_cleartext),
    .i_key(i_key),
    .i_dv(i_dv),
    .o_ciphertext(o_ciphertext),
    .o_dv(o_dv)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] ct;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   exp_dv;

  localparam int IP_R [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_R [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_R [0:47] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_R [0:31] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_R [0:55] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_R [0:47] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_R [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int S_R [0:511] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  // Reference works on 1-based bit arrays indexed by FIPS bit number.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] pt);
    bit kb [1:64];
    bit pb [1:64];
    bit ipb [1:64];
    bit cd [1:56];
    bit ks [1:16][1:48];
    bit l [1:32];
    bit r [1:32];
    bit xs [1:48];
    bit sv [1:32];
    bit nl [1:32];
    bit pre [1:64];
    bit t0, t1;
    int row, col, v;
    logic [63:0] ct;
    for (int i = 1; i <= 64; i++) begin
      kb[i] = key[64 - i];
      pb[i] = pt[64 - i];
    end
    for (int i = 1; i <= 56; i++) cd[i] = kb[PC1_R[i - 1]];
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int s = 0; s < SH_R[rnd]; s++) begin
        t0 = cd[1];
        t1 = cd[29];
        for (int j = 1; j < 28; j++) begin
          cd[j]      = cd[j + 1];
          cd[j + 28] = cd[j + 29];
        end
        cd[28] = t0;
        cd[56] = t1;
      end
      for (int j = 1; j <= 48; j++) ks[rnd + 1][j] = cd[PC2_R[j - 1]];
    end
    for (int i = 1; i <= 64; i++) ipb[i] = pb[IP_R[i - 1]];
    for (int i = 1; i <= 32; i++) begin
      l[i] = ipb[i];
      r[i] = ipb[i + 32];
    end
    for (int rnd = 1; rnd <= 16; rnd++) begin
      for (int j = 1; j <= 48; j++) xs[j] = r[E_R[j - 1]] ^ ks[rnd][j];
      for (int s = 0; s < 8; s++) begin
        row = 2 * int'(xs[6 * s + 1]) + int'(xs[6 * s + 6]);
        col = 8 * int'(xs[6 * s + 2]) + 4 * int'(xs[6 * s + 3]) + 2 * int'(xs[6 * s + 4]) + int'(xs[6 * s + 5]);
        v = S_R[s * 64 + row * 16 + col];
        for (int b = 0; b < 4; b++) sv[4 * s + 1 + b] = bit'((v >> (3 - b)) & 1);
      end
      for (int j = 1; j <= 32; j++) begin
        nl[j] = r[j];
        r[j]  = l[j] ^ sv[P_R[j - 1]];
        l[j]  = nl[j];
      end
    end
    for (int i = 1; i <= 32; i++) begin
      pre[i]      = r[i];
      pre[i + 32] = l[i];
    end
    ct = '0;
    for (int i = 1; i <= 64; i++) ct[64 - i] = pre[FP_R[i - 1]];
    return ct;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every cycle: o_dv must match the scoreboard's due time; valid data must match its entry.
  always @(negedge i_clk) begin
    if (mon_en) begin
      exp_dv = (sb.size() != 0) && (sb[0].due == cyc);
      chk("o_dv", {63'b0, o_dv}, {63'b0, exp_dv});
      if (exp_dv) begin
        chk("ciphertext", o_ciphertext, sb[0].ct);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step(input bit dv, input logic [63:0] key, input logic [63:0] pt,
                      input logic [63:0] ct);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_dv        = dv;
    i_key       = dv ? key : {$urandom, $urandom};
    i_cleartext = dv ? pt : {$urandom, $urandom};
    if (dv) begin
      e.ct  = ct;
      e.due = cyc + 17;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 64'h0, 64'h0, 64'h0);
  endtask

  initial begin
    logic [63:0] k, p;
    i_rst = 1'b1;
    i_dv = 1'b0;
    i_key = '0;
    i_cleartext = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_o_dv", {63'b0, o_dv}, 64'h0);
    chk("reset_ct", o_ciphertext, 64'h0);
    i_rst  = 1'b0;
    mon_en = 1'b1;

    step(1'b1, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    idle(20);

    step(1'b1, 64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7);
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58);
    step(1'b1, 64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815);
    idle(20);

    step(1'b1, 64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7);
    idle(2);
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58);
    idle(2);
    step(1'b1, 64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815);
    idle(20);

    step(1'b1, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    step(1'b1, 64'h123456789ABCDEF0, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    idle(20);

    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      step(1'b1, k, p, des_ref(k, p));
    end
    idle(20);

    for (int i = 0; i < 5; i++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      step(1'b1, k, p, des_ref(k, p));
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    i_dv  = 1'b1;
    sb.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_dv  = 1'b0;
    @(negedge i_clk);
    chk("midreset_ct", o_ciphertext, 64'h0);
    repeat (20) begin
      @(negedge i_clk);
      chk("midreset_quiet", {63'b0, o_dv}, 64'h0);
    end
    step(1'b1, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    idle(20);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge i_clk);
    chk("drain_left", 64'(sb.size()), 64'h0);
    @(negedge i_clk);
    chk("flushed_o_dv", {63'b0, o_dv}, 64'h0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
